// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus helpers for the multi-port MIPS register file.
package regfile_pkg;

    localparam int unsigned REG_WIDTH_DEF      = 32;
    localparam int unsigned REG_FILE_DEPTH_DEF = 32;
    localparam int unsigned REG_DIR_WIDTH_DEF  = 5;
    localparam int unsigned NUM_RD_DEF         = 2;
    localparam int unsigned ZERO_REG           = 0;

    // LSB position of port `port` inside a packed bus of `width`-bit slices.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, writeback clears it,
// and each read port reports whether its source is still outstanding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned REG_FILE_DEPTH = REG_FILE_DEPTH_DEF,
    parameter int unsigned REG_DIR_WIDTH  = REG_DIR_WIDTH_DEF,
    parameter int unsigned NUM_RD         = NUM_RD_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              iss_en,
    input  logic [REG_DIR_WIDTH-1:0]          iss_addr,
    input  logic                              wr0_en,
    input  logic [REG_DIR_WIDTH-1:0]          wr0_addr,
    input  logic                              wr1_en,
    input  logic [REG_DIR_WIDTH-1:0]          wr1_addr,
    input  logic [NUM_RD*REG_DIR_WIDTH-1:0]   rd_addr,
    output logic [REG_FILE_DEPTH-1:0]         busy_vec,
    output logic [NUM_RD-1:0]                 rd_busy
);

    logic [REG_FILE_DEPTH-1:0] busy_nxt;

    // Issue beats a same-cycle writeback: the write belongs to an older instruction.
    always_comb begin
        busy_nxt = busy_vec;
        for (int unsigned i = 1; i < REG_FILE_DEPTH; i++) begin
            if (iss_en && (iss_addr == REG_DIR_WIDTH'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if ((wr0_en && (wr0_addr == REG_DIR_WIDTH'(i))) ||
                         (wr1_en && (wr1_addr == REG_DIR_WIDTH'(i)))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    // A write landing this cycle is bypassed to the reader, so it no longer counts as busy.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
        logic [REG_DIR_WIDTH-1:0] src;
        assign src        = rd_addr[port_lsb(k, REG_DIR_WIDTH) +: REG_DIR_WIDTH];
        assign rd_busy[k] = busy_vec[src]
                          && !(wr0_en && (wr0_addr == src))
                          && !(wr1_en && (wr1_addr == src));
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: NUM_RD bypassed read ports, two writeback ports, r0 = 0,
// busy scoreboard and sticky write-conflict flag. Optional debug read port: REGFILE_DEBUG_PORT_EN.
module mips_regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = REG_WIDTH_DEF,
    parameter int unsigned REG_FILE_DEPTH = REG_FILE_DEPTH_DEF,
    parameter int unsigned REG_DIR_WIDTH  = REG_DIR_WIDTH_DEF,
    parameter int unsigned NUM_RD         = NUM_RD_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*REG_DIR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0]       rd_data,
    output logic [NUM_RD-1:0]                 rd_busy,
    input  logic                              wr0_en,
    input  logic [REG_DIR_WIDTH-1:0]          wr0_addr,
    input  logic [REG_WIDTH-1:0]              wr0_data,
    input  logic                              wr1_en,
    input  logic [REG_DIR_WIDTH-1:0]          wr1_addr,
    input  logic [REG_WIDTH-1:0]              wr1_data,
    input  logic                              iss_en,
    input  logic [REG_DIR_WIDTH-1:0]          iss_addr,
    output logic [REG_FILE_DEPTH-1:0]         busy_vec,
    output logic                              wr_conflict
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [REG_DIR_WIDTH-1:0]          dbg_addr,
    output logic [REG_WIDTH-1:0]              dbg_data
`endif
);

    logic [REG_WIDTH-1:0] regs [REG_FILE_DEPTH];
    logic                 we0;
    logic                 we1;
    logic                 same_dst;

    assign same_dst = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    assign we0      = wr0_en && (wr0_addr != REG_DIR_WIDTH'(ZERO_REG));
    assign we1      = wr1_en && (wr1_addr != REG_DIR_WIDTH'(ZERO_REG)) && !same_dst;

    // Storage; WB0 owns a shared destination, r0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_FILE_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we1) begin
                regs[wr1_addr] <= wr1_data;
            end
            if (we0) begin
                regs[wr0_addr] <= wr0_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_conflict <= 1'b0;
        end else if (we0 && same_dst) begin
            wr_conflict <= 1'b1;
        end
    end

    // Read ports: WB0 bypass over WB1 bypass over storage; r0 and reset force zero.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [REG_DIR_WIDTH-1:0] src;
        logic [REG_WIDTH-1:0]     val;

        assign src = rd_addr[port_lsb(k, REG_DIR_WIDTH) +: REG_DIR_WIDTH];

        always_comb begin
            val = regs[src];
            if (wr1_en && (wr1_addr == src)) begin
                val = wr1_data;
            end
            if (wr0_en && (wr0_addr == src)) begin
                val = wr0_data;
            end
            if (!rst || (src == REG_DIR_WIDTH'(ZERO_REG))) begin
                val = '0;
            end
        end

        assign rd_data[port_lsb(k, REG_WIDTH) +: REG_WIDTH] = val;
    end

    regfile_scoreboard #(
        .REG_FILE_DEPTH (REG_FILE_DEPTH),
        .REG_DIR_WIDTH  (REG_DIR_WIDTH),
        .NUM_RD         (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .rd_addr  (rd_addr),
        .busy_vec (busy_vec),
        .rd_busy  (rd_busy)
    );

`ifdef REGFILE_DEBUG_PORT_EN
    // Board display read: stored state only, one cycle behind dbg_addr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end
`endif

endmodule
